seg_countdown_ctrl: RTL and testbench
=====================================

// Module: seg_countdown_ctrl
// PURPOSE
//  Gesture-driven countdown-timer controller. Sequences a two-digit BCD seconds count (tens/units) into the
//  6-digit multiplexed seven-segment driver. Decodes gesture-recogniser command pulses into start/pause/clear/add.
//  Owns the 1 s timebase and the run/pause/done sequencing; the display driver only renders the digit codes.
// PARAMETERS
//  CNT_1S_MAX   50_000_000  sys_clk cycles per second tick (bench: 10)
//  PRESET_TENS  4'd2        tens digit loaded on reset/clear
//  PRESET_UNITS 4'd0        units digit loaded on reset/clear
//  GES_START    4'd1        ges_code: start/resume
//  GES_PAUSE    4'd2        ges_code: pause
//  GES_CLEAR    4'd3        ges_code: clear to preset
//  GES_ADD      4'd4        ges_code: +10 s (IDLE only)
// PORTS
//  sys_clk      in   1  system clock, 50 MHz
//  sys_rst      in   1  synchronous reset, active-high
//  ges_valid    in   1  one-cycle strobe, ges_code valid
//  ges_code     in   4  recognised gesture command
//  cnt_tens     out  4  tens digit to display driver; 4'hA = done glyph
//  cnt_units    out  4  units digit to display driver; 4'hA = done glyph
//  disp_blank   out  1  1 = driver blanks digits (pause blink phase)
//  state        out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//  done_pulse   out  1  one-cycle strobe on entry to DONE
// BEHAVIOUR
//  Reset (sync, sys_rst=1 at edge): state=IDLE, cnt_tens=PRESET_TENS, cnt_units=PRESET_UNITS,
//   disp_blank=0, done_pulse=0, prescaler=0, blink phase=0. Reset mid-run aborts immediately.
//  Prescaler: counts 0..CNT_1S_MAX-1 only in RUN; tick = (prescaler==CNT_1S_MAX-1); wraps to 0.
//   Held in PAUSE, cleared to 0 on IDLE->RUN and on any entry to IDLE.
//  Commands: acted on only when ges_valid=1; unknown codes and codes invalid for a state are ignored.
//  IDLE : START -> RUN (if count != 00; else stays IDLE). ADD -> tens+1, saturates at 9.
//         CLEAR -> reload preset. PAUSE ignored.
//  RUN  : on tick: units>0 -> units-1; units==0,tens>0 -> tens-1, units=9;
//         count==00 -> DONE, both digits=4'hA (00 is shown for one full second).
//         PAUSE -> PAUSE. CLEAR -> IDLE + preset. START/ADD ignored.
//  PAUSE: START -> RUN, prescaler resumes from held value. CLEAR -> IDLE + preset. Others ignored.
//         disp_blank toggles every CNT_1S_MAX/2 cycles (own half-second counter, reset on entry,
//         phase starts 0); disp_blank forced 0 in all other states.
//  DONE : digits held at 4'hA. CLEAR -> IDLE + preset. Others ignored. No timeout.
//  Simultaneous tick + command in RUN: decrement (or DONE transition) is applied that cycle;
//   a PAUSE/CLEAR command also takes effect that cycle. CLEAR overrides the decrement (preset loaded).
//   Tick at 00 with PAUSE: DONE wins.
//  done_pulse: registered, high exactly the cycle after the RUN->DONE transition edge, i.e. first
//   cycle state==DONE.
//  All outputs registered; command-to-state latency = 1 cycle; tick-to-digit latency = 1 cycle.
//  Digits are always valid BCD 0..9 or 4'hA; never any other value.
// STRUCTURE
//  Shared header: gesture command codes, state encodings, DONE glyph code 4'hA
//   (also used by seg_dynamic decode).
//  Sub-module seg_tick_gen: parameterised prescaler with enable/clear, outputs tick and half_tick.
//  Top: FSM + BCD down-counter + blink register; single always block per register group.
// TESTING  (CNT_1S_MAX=10, preset 20)
//  1 reset, START, run 21 ticks -> digits 20,19..00, then AA; done_pulse once; state=DONE.
//  2 RUN at 15, PAUSE -> digits frozen 30 cycles, blank toggles every 5; START -> resumes, next tick
//    at held phase.
//  3 IDLE: ADD x9 -> tens saturates 9 (count 90); CLEAR -> 20; PAUSE in IDLE -> no change.
//  4 ges PAUSE on tick cycle at 13 -> shows 12, state PAUSE; CLEAR on tick cycle -> 20, IDLE.
//  5 sys_rst asserted mid-RUN at 07 -> next cycle IDLE, 20, prescaler 0, blank 0.
//  6 DONE: START/ADD/PAUSE ignored (AA held); CLEAR -> IDLE 20; invalid code 4'hF ignored in
//    every state.

Source files
------------

// File: rtl/seg_countdown_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seg_countdown_ctrl_pkg
//   Shared definitions for the gesture-driven countdown controller and the
//   seven-segment display path.
//   - Gesture command codes delivered by the gesture recogniser.
//   - Controller state encoding, which is also exported on the 'state' port.
//   - DONE glyph digit code. seg_dynamic decodes the same value, so both
//     sides must agree on it.
//   - A helper for the saturating +10 s (tens digit) adjustment.
// ----------------------------------------------------------------------------
package seg_countdown_ctrl_pkg;

    // Gesture command codes.
    localparam logic [3:0] GES_CODE_START = 4'd1;
    localparam logic [3:0] GES_CODE_PAUSE = 4'd2;
    localparam logic [3:0] GES_CODE_CLEAR = 4'd3;
    localparam logic [3:0] GES_CODE_ADD   = 4'd4;

    // Digit code that the display driver renders as the "done" glyph.
    localparam logic [3:0] DONE_GLYPH = 4'hA;

    // Largest legal BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Controller states. The encoding is visible on the 'state' output port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } cd_state_t;

    // Tens digit plus one, clamped at 9, so the count never leaves BCD range.
    function automatic logic [3:0] tens_add_sat(input logic [3:0] tens);
        return (tens >= BCD_MAX) ? BCD_MAX : tens + 4'd1;
    endfunction

endpackage

// File: rtl/seg_countdown_ctrl_tick_gen.sv
// ----------------------------------------------------------------------------
// seg_tick_gen
//   Timebase for the countdown controller. It holds two independent counters:
//   - 1 s prescaler: counts 0..CNT_MAX-1 while cnt_en is high and wraps to 0.
//     'tick' is high during the last count of each period. The value is held
//     while cnt_en is low, and cnt_clr forces it to 0.
//   - Half-second counter: counts 0..CNT_MAX/2-1 while half_en is high.
//     'half_tick' is high during the last count of each half period. half_clr
//     forces it to 0, so the first half period is always a full one.
// Ports
//   sys_clk    in  1  system clock
//   sys_rst    in  1  synchronous reset, active-high
//   cnt_en     in  1  advance the 1 s prescaler
//   cnt_clr    in  1  clear the 1 s prescaler (takes priority over cnt_en)
//   half_en    in  1  advance the half-second counter
//   half_clr   in  1  clear the half-second counter (takes priority over half_en)
//   tick       out 1  1 s boundary; only asserted while cnt_en is high
//   half_tick  out 1  half-second boundary; only asserted while half_en is high
// ----------------------------------------------------------------------------
module seg_tick_gen #(
    parameter int unsigned CNT_MAX = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic cnt_en,
    input  logic cnt_clr,
    input  logic half_en,
    input  logic half_clr,
    output logic tick,
    output logic half_tick
);

    localparam int unsigned HALF_MAX = (CNT_MAX >= 2) ? (CNT_MAX / 2) : 1;
    localparam int unsigned CW       = (CNT_MAX  > 1) ? $clog2(CNT_MAX)  : 1;
    localparam int unsigned HW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [CW-1:0] PRESC_LAST = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_MAX - 1);

    logic [CW-1:0] presc;
    logic [HW-1:0] half_cnt;

    assign tick      = cnt_en  && (presc    == PRESC_LAST);
    assign half_tick = half_en && (half_cnt == HALF_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || cnt_clr) begin
            presc <= '0;
        end else if (cnt_en) begin
            presc <= tick ? '0 : presc + CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || half_clr) begin
            half_cnt <= '0;
        end else if (half_en) begin
            half_cnt <= half_tick ? '0 : half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/seg_countdown_ctrl.sv
// ----------------------------------------------------------------------------
// seg_countdown_ctrl
//   Gesture-driven countdown timer controller. It decodes gesture command
//   strobes into start/pause/clear/add actions. It counts a two-digit BCD
//   seconds value down once per second and tracks the run, pause and done
//   phases. The display driver only renders cnt_tens and cnt_units; in DONE
//   both digits carry the DONE glyph code.
// Ports
//   sys_clk     in  1  system clock (50 MHz)
//   sys_rst     in  1  synchronous reset, active-high
//   ges_valid   in  1  one-cycle strobe; ges_code is valid
//   ges_code    in  4  recognised gesture command
//   cnt_tens    out 4  tens digit (0..9, or 4'hA in DONE)
//   cnt_units   out 4  units digit (0..9, or 4'hA in DONE)
//   disp_blank  out 1  blank the digits (blink phase, PAUSE only)
//   state       out 2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done_pulse  out 1  high for the first cycle spent in DONE
// ----------------------------------------------------------------------------
module seg_countdown_ctrl
    import seg_countdown_ctrl_pkg::*;
#(
    parameter int unsigned CNT_1S_MAX   = 50_000_000,
    parameter logic [3:0]  PRESET_TENS  = 4'd2,
    parameter logic [3:0]  PRESET_UNITS = 4'd0,
    parameter logic [3:0]  GES_START    = GES_CODE_START,
    parameter logic [3:0]  GES_PAUSE    = GES_CODE_PAUSE,
    parameter logic [3:0]  GES_CLEAR    = GES_CODE_CLEAR,
    parameter logic [3:0]  GES_ADD      = GES_CODE_ADD
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       ges_valid,
    input  logic [3:0] ges_code,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_units,
    output logic       disp_blank,
    output logic [1:0] state,
    output logic       done_pulse
);

    cd_state_t  st, st_n;
    logic [3:0] tens_n, units_n;
    logic       tick, half_tick;

    logic cmd_start, cmd_pause, cmd_clear, cmd_add;
    logic count_zero;

    assign cmd_start  = ges_valid && (ges_code == GES_START);
    assign cmd_pause  = ges_valid && (ges_code == GES_PAUSE);
    assign cmd_clear  = ges_valid && (ges_code == GES_CLEAR);
    assign cmd_add    = ges_valid && (ges_code == GES_ADD);
    assign count_zero = (cnt_tens == 4'd0) && (cnt_units == 4'd0);

    assign state = st;

    // The prescaler is held at 0 for the whole of IDLE. This gives the same
    // result as clearing it on entry to IDLE and again on IDLE->RUN, because
    // RUN can only be entered from IDLE while the prescaler is 0.
    seg_tick_gen #(
        .CNT_MAX (CNT_1S_MAX)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cnt_en    (st == ST_RUN),
        .cnt_clr   (st == ST_IDLE),
        .half_en   (st == ST_PAUSE),
        .half_clr  (st != ST_PAUSE),
        .tick      (tick),
        .half_tick (half_tick)
    );

    // Next-state and next-digit logic.
    always_comb begin
        st_n    = st;
        tens_n  = cnt_tens;
        units_n = cnt_units;

        case (st)
            ST_IDLE: begin
                if (cmd_start && !count_zero) begin
                    st_n = ST_RUN;
                end else if (cmd_add) begin
                    tens_n = tens_add_sat(cnt_tens);
                end else if (cmd_clear) begin
                    tens_n  = PRESET_TENS;
                    units_n = PRESET_UNITS;
                end
            end

            ST_RUN: begin
                // The tick is applied first. A CLEAR in the same cycle then
                // overrides it. A PAUSE in the same cycle does not cancel a
                // transition into DONE.
                if (tick) begin
                    if (cnt_units != 4'd0) begin
                        units_n = cnt_units - 4'd1;
                    end else if (cnt_tens != 4'd0) begin
                        tens_n  = cnt_tens - 4'd1;
                        units_n = BCD_MAX;
                    end else begin
                        st_n    = ST_DONE;
                        tens_n  = DONE_GLYPH;
                        units_n = DONE_GLYPH;
                    end
                end
                if (cmd_clear) begin
                    st_n    = ST_IDLE;
                    tens_n  = PRESET_TENS;
                    units_n = PRESET_UNITS;
                end else if (cmd_pause && (st_n != ST_DONE)) begin
                    st_n = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (cmd_start) begin
                    st_n = ST_RUN;
                end else if (cmd_clear) begin
                    st_n    = ST_IDLE;
                    tens_n  = PRESET_TENS;
                    units_n = PRESET_UNITS;
                end
            end

            ST_DONE: begin
                if (cmd_clear) begin
                    st_n    = ST_IDLE;
                    tens_n  = PRESET_TENS;
                    units_n = PRESET_UNITS;
                end
            end

            default: begin
                st_n = ST_IDLE;
            end
        endcase
    end

    // State and digit registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st        <= ST_IDLE;
            cnt_tens  <= PRESET_TENS;
            cnt_units <= PRESET_UNITS;
        end else begin
            st        <= st_n;
            cnt_tens  <= tens_n;
            cnt_units <= units_n;
        end
    end

    // Blink register. It is forced to 0 outside PAUSE, so every entry into
    // PAUSE starts in the visible phase.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            disp_blank <= 1'b0;
        end else if (st_n == ST_PAUSE) begin
            disp_blank <= disp_blank ^ half_tick;
        end else begin
            disp_blank <= 1'b0;
        end
    end

    // Done strobe. It is registered from the RUN->DONE decision, so it is
    // high on exactly the first cycle in which state reads DONE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= (st == ST_RUN) && (st_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_seg_countdown_ctrl.sv
module tb_seg_countdown_ctrl;

    localparam int TB_CNT  = 10;
    localparam int TB_HALF = TB_CNT / 2;
    localparam int PRESET  = 20;

    localparam logic [3:0] C_START = 4'd1;
    localparam logic [3:0] C_PAUSE = 4'd2;
    localparam logic [3:0] C_CLEAR = 4'd3;
    localparam logic [3:0] C_ADD   = 4'd4;
    localparam logic [3:0] C_BAD   = 4'hF;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       ges_valid = 1'b0;
    logic [3:0] ges_code = 4'd0;
    logic [3:0] cnt_tens, cnt_units;
    logic       disp_blank;
    logic [1:0] state;
    logic       done_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: seconds held as a plain integer, state 0..3,
    // run-time phase within the current second, and time spent in pause.
    int m_state = 0;
    int m_secs  = PRESET;
    int m_phase = 0;
    int m_age   = 0;
    bit m_dp    = 1'b0;
    int dp_count = 0;

    seg_countdown_ctrl #(
        .CNT_1S_MAX (TB_CNT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ges_valid  (ges_valid),
        .ges_code   (ges_code),
        .cnt_tens   (cnt_tens),
        .cnt_units  (cnt_units),
        .disp_blank (disp_blank),
        .state      (state),
        .done_pulse (done_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input logic [3:0] code);
        int  ns;
        bit  tk;
        if (rst) begin
            m_state = 0; m_secs = PRESET; m_phase = 0; m_age = 0; m_dp = 1'b0;
            return;
        end
        ns   = m_state;
        m_dp = 1'b0;
        case (m_state)
            0: begin
                if (v && code == C_START && m_secs != 0) ns = 1;
                else if (v && code == C_ADD) begin
                    if (m_secs < 90) m_secs += 10;
                end else if (v && code == C_CLEAR) m_secs = PRESET;
            end
            1: begin
                tk = (m_phase == TB_CNT - 1);
                m_phase = (m_phase + 1) % TB_CNT;
                if (tk) begin
                    if (m_secs == 0) ns = 3;
                    else m_secs -= 1;
                end
                if (v && code == C_CLEAR) begin
                    ns = 0; m_secs = PRESET;
                end else if (v && code == C_PAUSE && ns != 3) begin
                    ns = 2; m_age = 0;
                end
                if (ns == 3) m_dp = 1'b1;
            end
            2: begin
                m_age++;
                if (v && code == C_START) ns = 1;
                else if (v && code == C_CLEAR) begin
                    ns = 0; m_secs = PRESET;
                end
            end
            default: begin
                if (v && code == C_CLEAR) begin
                    ns = 0; m_secs = PRESET;
                end
            end
        endcase
        if (ns == 0) m_phase = 0;
        m_state = ns;
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, and compare on the next falling edge.
    task automatic cycle(input bit rst, input bit v, input logic [3:0] code);
        int et, eu;
        bit eb;
        sys_rst = rst; ges_valid = v; ges_code = code;
        @(posedge sys_clk);
        model_step(rst, v, code);
        @(negedge sys_clk);
        et = (m_state == 3) ? 10 : m_secs / 10;
        eu = (m_state == 3) ? 10 : m_secs % 10;
        eb = (m_state == 2) && (((m_age / TB_HALF) % 2) == 1);
        check_val("state", 32'(state), 32'(m_state));
        check_val("tens", 32'(cnt_tens), 32'(et));
        check_val("units", 32'(cnt_units), 32'(eu));
        check_val("blank", 32'(disp_blank), 32'(eb));
        check_val("done_pulse", 32'(done_pulse), 32'(m_dp));
        if (done_pulse === 1'b1) dp_count++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0);
    endtask

    task automatic cmd(input logic [3:0] code);
        cycle(1'b0, 1'b1, code);
    endtask

    // Run until the model shows the given count in RUN, optionally on the
    // tick cycle itself. The wait is bounded; an expired bound is a failure.
    task automatic run_until(input int secs, input bit on_tick, input int maxc, input string tag);
        int k = 0;
        while (!(m_state == 1 && m_secs == secs && (!on_tick || m_phase == TB_CNT - 1)) && k < maxc) begin
            cycle(1'b0, 1'b0, 4'd0);
            k++;
        end
        check_val(tag, 32'(k < maxc), 32'd1);
    endtask

    initial begin
        int r, c;
        bit v, rst;
        @(negedge sys_clk);
        cycle(1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 4'd0);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_digits", 32'({cnt_tens, cnt_units}), 32'h20);

        // Full countdown 20 -> 00 -> AA.
        dp_count = 0;
        cmd(C_START);
        idle(215);
        check_val("t1_state", 32'(state), 32'd3);
        check_val("t1_glyph", 32'({cnt_tens, cnt_units}), 32'hAA);
        check_val("t1_done_pulses", 32'(dp_count), 32'd1);

        // Pause at 15, blink, resume.
        cmd(C_CLEAR);
        cmd(C_START);
        run_until(15, 1'b0, 300, "t2_reach15");
        idle(3);
        cmd(C_PAUSE);
        idle(30);
        check_val("t2_frozen", 32'({cnt_tens, cnt_units}), 32'h15);
        cmd(C_START);
        idle(40);

        // IDLE: ADD saturation, CLEAR, PAUSE ignored.
        cmd(C_CLEAR);
        for (int i = 0; i < 9; i++) cmd(C_ADD);
        check_val("t3_add_sat", 32'({cnt_tens, cnt_units}), 32'h90);
        cmd(C_CLEAR);
        check_val("t3_clear", 32'({cnt_tens, cnt_units}), 32'h20);
        cmd(C_PAUSE);
        check_val("t3_pause_idle", 32'(state), 32'd0);

        // Commands on the tick cycle.
        cmd(C_START);
        run_until(13, 1'b1, 300, "t4_reach13");
        cmd(C_PAUSE);
        check_val("t4_pause_tick_digits", 32'({cnt_tens, cnt_units}), 32'h12);
        check_val("t4_pause_tick_state", 32'(state), 32'd2);
        cmd(C_START);
        run_until(12, 1'b1, 300, "t4_reach_tick");
        cmd(C_CLEAR);
        check_val("t4_clear_tick_digits", 32'({cnt_tens, cnt_units}), 32'h20);
        check_val("t4_clear_tick_state", 32'(state), 32'd0);

        // Reset mid-run.
        cmd(C_START);
        run_until(7, 1'b0, 300, "t5_reach07");
        cycle(1'b1, 1'b0, 4'd0);
        check_val("t5_rst_state", 32'(state), 32'd0);
        check_val("t5_rst_digits", 32'({cnt_tens, cnt_units}), 32'h20);
        check_val("t5_rst_blank", 32'(disp_blank), 32'd0);
        cmd(C_START);
        idle(25);

        // DONE: commands ignored except CLEAR; 4'hF ignored everywhere.
        idle(200);
        check_val("t6_done", 32'(state), 32'd3);
        cmd(C_START); cmd(C_ADD); cmd(C_PAUSE); cmd(C_BAD);
        check_val("t6_done_hold", 32'({cnt_tens, cnt_units}), 32'hAA);
        cmd(C_CLEAR);
        check_val("t6_done_clear", 32'({cnt_tens, cnt_units}), 32'h20);
        cmd(C_BAD);
        cmd(C_START); cmd(C_BAD);
        cmd(C_PAUSE); cmd(C_BAD);
        idle(12);
        check_val("t6_bad_pause", 32'(state), 32'd2);
        cmd(C_START); idle(5); cmd(C_CLEAR);

        // Randomized traffic against the model.
        for (int n = 0; n < 20000; n++) begin
            rst = ($urandom_range(0, 2999) == 0);
            v   = ($urandom_range(0, 47) == 0);
            r   = $urandom_range(0, 99);
            if (r < 30)      c = 1;
            else if (r < 45) c = 2;
            else if (r < 55) c = 3;
            else if (r < 75) c = 4;
            else begin
                c = $urandom_range(5, 16);
                if (c == 16) c = 0;
            end
            if (!v) c = $urandom_range(0, 15);
            cycle(rst, v, 4'(c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
